// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: oversampled UART receive frame FSM; define RX_FRAME_CTRL_BREAK_DET_EN to add break detection
module rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  rx_clk,
  input  logic                  resetn,
  input  logic                  baud_tick,
  input  logic                  rx_in,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  output logic                  shift,
  output logic                  parity_load,
  output logic                  check_stop,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  break_det,
  output logic                  busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] C_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [DATA_WIDTH-1:0] shreg;
  logic par_en_l, par_odd_l, par_err_i, wait_high, start_ok, accept;
  assign busy     = state != IDLE;
  assign start_ok = state == START && state_n == DATA;
  assign accept   = !rx_valid || rx_ready;
  always_ff @(posedge rx_clk)
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bcnt  <= bcnt_n;
    end
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bcnt_n      = bcnt;
    shift       = 1'b0;
    parity_load = 1'b0;
    check_stop  = 1'b0;
    if (baud_tick) begin
      cnt_n = cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt_n  = '0;
          bcnt_n = '0;
          state_n = (!rx_in && !wait_high) ? START : IDLE;
        end
        START: if (cnt == C_HALF) begin
          cnt_n   = '0;
          state_n = rx_in ? IDLE : DATA;
        end
        DATA: if (cnt == C_LAST) begin
          cnt_n  = '0;
          shift  = 1'b1;
          bcnt_n = bcnt + 1'b1;
          if (bcnt == B_LAST) state_n = par_en_l ? PARITY : STOP;
        end
        PARITY: if (cnt == C_LAST) begin
          cnt_n       = '0;
          parity_load = 1'b1;
          state_n     = STOP;
        end
        STOP: if (cnt == C_LAST) begin
          cnt_n      = '0;
          check_stop = 1'b1;
          state_n    = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge rx_clk)
    if (!resetn) begin
      shreg      <= '0;
      par_en_l   <= 1'b0;
      par_odd_l  <= 1'b0;
      par_err_i  <= 1'b0;
      wait_high  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (start_ok) begin
        par_en_l  <= parity_en;
        par_odd_l <= parity_odd;
        par_err_i <= 1'b0;
      end
      if (shift) shreg <= {rx_in, shreg[DATA_WIDTH-1:1]};
      if (parity_load) par_err_i <= ^shreg ^ rx_in ^ par_odd_l;
      if (check_stop && !rx_in) wait_high <= 1'b1;
      else if (baud_tick && state == IDLE && rx_in) wait_high <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      if (check_stop && accept) begin
        rx_data    <= shreg;
        parity_err <= par_err_i;
        frame_err  <= !rx_in;
        rx_valid   <= 1'b1;
      end else if (check_stop) overrun <= 1'b1;
    end
`ifdef RX_FRAME_CTRL_BREAK_DET_EN
  logic all_zero, brk;
  always_ff @(posedge rx_clk)
    if (!resetn) begin
      all_zero <= 1'b0;
      brk      <= 1'b0;
    end else begin
      if (start_ok) all_zero <= 1'b1;
      else if ((shift || parity_load) && rx_in) all_zero <= 1'b0;
      brk <= check_stop && accept && all_zero && !rx_in;
    end
  assign break_det = brk;
`else
  assign break_det = 1'b0;
`endif
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: scoreboard bench for rx_frame_ctrl (DATA_WIDTH=8, OVERSAMPLE=16, baud_tick every cycle)
module tb_rx_frame_ctrl;
  logic clk = 1'b0, resetn = 1'b0, rx_in = 1'b1, parity_en = 1'b0, parity_odd = 1'b0, rx_ready = 1'b1;
  logic shift, parity_load, check_stop, rx_valid, parity_err, frame_err, overrun, break_det, busy;
  logic [7:0] rx_data;
  typedef struct packed {logic [7:0] d; logic pe, fe, bk;} exp_t;
  exp_t sb[$];
  exp_t e;
  int n_chk = 0, n_pass = 0, cyc_n = 0, last_shift = -1000, n_shift = 0, n_pload = 0;
  logic rv_prev = 1'b0, hs_prev = 1'b0, nw;
`ifdef RX_FRAME_CTRL_BREAK_DET_EN
  localparam logic BRK = 1'b1;
`else
  localparam logic BRK = 1'b0;
`endif
  rx_frame_ctrl #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
    .rx_clk(clk), .resetn(resetn), .baud_tick(1'b1), .rx_in(rx_in),
    .parity_en(parity_en), .parity_odd(parity_odd), .shift(shift),
    .parity_load(parity_load), .check_stop(check_stop), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .break_det(break_det), .busy(busy)
  );
  initial forever #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic bit_out(input logic b);
    rx_in = b;
    cyc(16);
  endtask
  task automatic send(input logic [7:0] d, input logic pen, input logic podd, input logic flip,
                      input logic stopb, input logic push);
    logic pbit;
    pbit = (podd ? ~^d : ^d) ^ flip;
    parity_en = pen;
    parity_odd = podd;
    if (push) sb.push_back('{d, pen & flip, !stopb, BRK && d == 8'h00 && !(pen && pbit) && !stopb});
    bit_out(1'b0);
    parity_en = ~pen;
    parity_odd = ~podd;
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    if (pen) bit_out(pbit);
    bit_out(stopb);
  endtask
  always @(negedge clk) begin
    cyc_n++;
    nw = rx_valid && (!rv_prev || hs_prev);
    if (resetn) begin
      if (shift + parity_load + check_stop > 1) check("strobe_excl", 1, 0);
      if (shift) begin
        if (cyc_n - last_shift < 40) check("shift_gap", cyc_n - last_shift, 16);
        last_shift = cyc_n;
        n_shift++;
      end
      if (parity_load) n_pload++;
      if (break_det && !nw) check("brk_stray", 1, 0);
      if (nw) begin
        if (sb.size() == 0) check("sb_empty", rx_data, 32'hffff_ffff);
        else begin
          e = sb.pop_front();
          check("rx_data", rx_data, e.d);
          check("parity_err", parity_err, e.pe);
          check("frame_err", frame_err, e.fe);
          check("break_det", break_det, e.bk);
        end
      end
    end
    rv_prev = rx_valid;
    hs_prev = rx_valid && rx_ready;
  end
  initial begin
    int s0;
    cyc(3);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {parity_err, frame_err, overrun, break_det}, 0);
    check("rst_strobes", {shift, parity_load, check_stop}, 0);
    resetn = 1'b1;
    cyc(5);
    s0 = n_shift;
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    rx_in = 1'b1;
    cyc(20);
    check("a5_shifts", n_shift - s0, 8);
    check("a5_overrun", overrun, 0);
    check("a5_pload", n_pload, 0);
    send(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    rx_in = 1'b1;
    cyc(20);
    send(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    rx_in = 1'b1;
    cyc(20);
    check("par_pload", n_pload, 2);
    s0 = n_shift;
    rx_in = 1'b0;
    cyc(5);
    rx_in = 1'b1;
    cyc(40);
    check("false_start_shift", n_shift - s0, 0);
    check("false_start_busy", busy, 0);
    check("false_start_valid", rx_valid, 0);
    rx_ready = 1'b0;
    send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    rx_in = 1'b1;
    cyc(4);
    send(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rx_in = 1'b1;
    cyc(20);
    check("ovr_data", rx_data, 8'h3C);
    check("ovr_flag", overrun, 1);
    check("ovr_valid", rx_valid, 1);
    rx_ready = 1'b1;
    cyc(1);
    check("ovr_clr_valid", rx_valid, 0);
    check("ovr_clr_flag", overrun, 0);
    cyc(10);
    send(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    s0 = n_shift;
    cyc(40);
    check("brk_hold_busy", busy, 0);
    check("brk_hold_shift", n_shift - s0, 0);
    rx_in = 1'b1;
    cyc(20);
    parity_en = 1'b0;
    rx_in = 1'b0;
    cyc(16);
    for (int i = 0; i < 4; i++) bit_out(1'b1);
    rx_in = 1'b1;
    cyc(8);
    check("mid_busy", busy, 1);
    resetn = 1'b0;
    cyc(1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", rx_valid, 0);
    resetn = 1'b1;
    cyc(20);
    send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    rx_in = 1'b1;
    cyc(20);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame (5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, baud_tick pulses per bit period (even, >=4).
REQ-003 SHALL have port rx_clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port baud_tick  input  1  one-cycle oversample enable, OVERSAMPLE per bit.
REQ-006 SHALL have port rx_in  input  1  serial line, already synchronised; idle high.
REQ-007 SHALL have port parity_en  input  1  1 = frame carries a parity bit.
REQ-008 SHALL have port parity_odd  input  1  1 = odd parity, 0 = even.
REQ-009 SHALL have port shift, parity_load, check_stop  output  1 each  one-cycle datapath strobes.
REQ-010 SHALL have port rx_data  output  DATA_WIDTH  received word, LSB first on line.
REQ-011 SHALL have port rx_valid  output  1  rx_data holds an unread word.
REQ-012 SHALL have port rx_ready  input  1  consumer accepts word when rx_valid && rx_ready.
REQ-013 SHALL have ports parity_err, frame_err, overrun, break_det  output  1 each  status flags.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP; all state changes and counter updates occur only on cycles where baud_tick=1.
REQ-016 IDLE: on baud_tick with rx_in=0, go to START and clear the tick counter.
REQ-017 START: at tick count OVERSAMPLE/2-1, rx_in=0 -> DATA with counter cleared; rx_in=1 -> IDLE (false start, no flags changed).
REQ-018 DATA: every OVERSAMPLE ticks sample rx_in, pulse shift for that cycle, shift into internal register LSB first; after DATA_WIDTH samples go to PARITY if parity_en else STOP.
REQ-019 PARITY: after OVERSAMPLE ticks sample rx_in, pulse parity_load; internal parity error = (XOR of data bits ^ sampled bit ^ parity_odd) != 0... i.e. error when total ones count parity mismatches the selected mode; go to STOP.
REQ-020 STOP: after OVERSAMPLE ticks sample rx_in, pulse check_stop; stop sample 0 = frame error; go to IDLE.
REQ-021 Cycle after check_stop: rx_data, parity_err, frame_err load together and rx_valid=1 (latency 1 cycle from stop sample).
REQ-022 parity_err SHALL be 0 for frames received with parity_en=0.
REQ-023 rx_valid SHALL clear the cycle after rx_valid && rx_ready; data and flags hold until then.
REQ-024 Frame completes while rx_valid=1 and rx_ready=0: new frame discarded, rx_data unchanged, overrun set (sticky).
REQ-025 Frame completes in the same cycle as a handshake: no overrun, new word loaded, rx_valid stays 1.
REQ-026 overrun SHALL clear on the next handshake.
REQ-027 parity_en/parity_odd SHALL be sampled only at the START->DATA transition; changes mid-frame have no effect on that frame.
REQ-028 shift, parity_load, check_stop SHALL never be high in the same cycle.
REQ-029 In STOP with frame_err, next IDLE entry SHALL require rx_in=1 on a baud_tick before a new start is accepted.

Reset
REQ-030 resetn=0 on a rising edge SHALL force IDLE, counters 0, rx_data=0, all strobes, rx_valid, all flags, busy = 0.
REQ-031 Reset mid-frame SHALL abandon the frame with no partial word delivered.

Configuration
REQ-032 Macro RX_FRAME_CTRL_BREAK_DET_EN: defined -> break_det pulses one cycle together with rx_valid when all data bits, parity bit (if any) and stop bit sampled 0; frame_err also set.
REQ-033 Macro undefined -> break_det tied 0, no break logic synthesised; all other behaviour identical.

Verification (DATA_WIDTH=8, OVERSAMPLE=16, baud_tick every cycle)
REQ-034 Frame 0xA5, parity_en=0, stop=1 -> shift 8 pulses 16 cycles apart, rx_data=0xA5, rx_valid=1, all flags 0.
REQ-035 0xA5, parity_en=1, parity_odd=0, parity bit 1 -> parity_err=1, frame_err=0, rx_data=0xA5.
REQ-036 Start low 5 ticks then high -> returns IDLE, no shift pulse, rx_valid stays 0.
REQ-037 Two frames 0x3C, 0xC3 with rx_ready=0 -> rx_data=0x3C, overrun=1; raise rx_ready -> rx_valid 0, overrun 0.
REQ-038 All-zero frame incl. stop, macro defined -> rx_data=0x00, frame_err=1, break_det one-cycle pulse; macro undefined -> break_det 0.
REQ-039 resetn=0 during DATA bit 4 -> IDLE next cycle, busy=0, rx_valid=0; following clean frame 0x5A received correctly.
